mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
//  Multi-cycle integer multiply/divide unit for the MIPS pipeline (MULT, MULTU, DIV, DIVU).
//  Sits in EX beside the ALU. Consumes forwarded rs/rt operands and produces the 64-bit {hi,lo} result.
//  The result feeds the HI/LO register pair via a one-cycle write-enable pulse.
//  Stalls the pipeline through busy while an operation iterates (radix-2, one bit per cycle).
// PARAMETERS
//  WIDTH   32   operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-high
//  start     in   1      request new op; sampled only when idle or done
//  op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a         in   WIDTH  rs: multiplicand / dividend
//  b         in   WIDTH  rt: multiplier / divisor
//  flush     in   1      abort in-flight op (branch/exception squash)
//  busy      out  1      op in progress; hazard unit stalls mfhi/mflo/new mdu ops
//  done      out  1      one-cycle pulse; hi/lo valid this cycle
//  hilo_we   out  1      equal to done; write enable for HI/LO registers
//  hi        out  WIDTH  product[63:32] / remainder
//  lo        out  WIDTH  product[31:0]  / quotient
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hilo_we=0, hi=0, lo=0, counter=0.
//  FSM: IDLE -> RUN -> FIX -> DONE -> IDLE. busy=1 in RUN and FIX only.
//  IDLE/DONE with start=1 at edge E: latch op, |a|, |b|, sign flags; go to RUN with count=0.
//   Signed ops take magnitudes; unsigned ops pass operands through.
//  RUN: one iteration per edge for WIDTH edges, then FIX.
//   MUL: shift-add, 2*WIDTH-bit accumulator.
//   DIV: restoring; shift remainder left, trial subtract, set quotient bit.
//  FIX: one edge. Negate product if sign(a)^sign(b) (signed MULT).
//   Signed DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
//  DONE: done=hilo_we=1 for exactly one cycle; returns to IDLE unless start (back-to-back accepted).
//  Latency: done high in the cycle after edge E+WIDTH+1, i.e. WIDTH+2 cycles after the start cycle (34 at default).
//  hi/lo are registered and update only on FIX->DONE; they hold their value otherwise.
//  start while busy=1: ignored, no queueing.
//  Divide by zero: no trap. lo=all ones, hi=a (raw dividend). Signed and unsigned alike; same latency.
//  DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps; no overflow flag).
//  Arithmetic is modulo 2^WIDTH per half. Magnitude of INT_MIN is held in an unsigned WIDTH-bit register.
//  flush: when busy, state goes to IDLE next edge. No done is produced and hi/lo are unchanged.
//   flush in DONE is ignored (the write has already been committed).
//  flush with start in the same cycle: flush wins; nothing is launched.
//  reset mid-operation: immediate return to reset values; no done.
// STRUCTURE
//  mdu_pkg contains:
//   typedef enum logic [1:0] mdu_op_t {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}
//   typedef enum mdu_state_t {IDLE, RUN, FIX, DONE}
//   localparam MDU_LATENCY = WIDTH+2
//  Sub-module mdu_negate: combinational conditional two's-complement negate (WIDTH-bit).
//   Instanced for operand abs, quotient fix and remainder fix.
//  Datapath: 2*WIDTH accumulator register, WIDTH divisor/multiplicand register,
//   $clog2(WIDTH)+1 counter, one FSM.
// TESTING
//  MULT a=7, b=0xFFFFFFFD -> done 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB, hilo_we=1 for 1 cycle.
//  MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=1.
//  DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x64. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  start pulsed at cycle 5 of an op -> ignored; flush at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged.
//  reset asserted mid-RUN -> all outputs 0 asynchronously; back-to-back start in DONE -> second done 34 cycles later.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH   = 32;
    // Start cycle to done cycle: one load edge, WIDTH iterations, one fix-up edge.
    localparam int MDU_LATENCY = MDU_WIDTH + 2;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef logic [1:0] mdu_state_t;

    localparam mdu_state_t IDLE = 2'd0;
    localparam mdu_state_t RUN  = 2'd1;
    localparam mdu_state_t FIX  = 2'd2;
    localparam mdu_state_t DONE = 2'd3;

    function automatic logic op_is_signed(input logic [1:0] o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module mdu_negate #(
    parameter int WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = en ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mdu_iterative.sv
// Radix-2 iterative multiply/divide unit producing {hi,lo} for MULT/MULTU/DIV/DIVU.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_t         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      count_q, count_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               a_neg, b_neg, launch;
    logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix, mul_next, div_next;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic               fits;

    assign a_neg  = op_is_signed(op) & a[WIDTH-1];
    assign b_neg  = op_is_signed(op) & b[WIDTH-1];
    // flush has priority over start; DONE accepts a new op back-to-back.
    assign launch = start & ~flush & ((state_q == IDLE) | (state_q == DONE));

    mdu_negate #(.WIDTH(WIDTH)) u_abs_a (.en(a_neg), .din(a), .dout(a_abs));
    mdu_negate #(.WIDTH(WIDTH)) u_abs_b (.en(b_neg), .din(b), .dout(b_abs));
    // Divide by zero keeps the all-ones quotient regardless of operand signs.
    mdu_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .en  (neg_res_q & ~b_zero_q),
        .din (acc_q[WIDTH-1:0]),
        .dout(quo_fix)
    );
    mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .en  (neg_rem_q),
        .din (acc_q[2*WIDTH-1:WIDTH]),
        .dout(rem_fix)
    );
    mdu_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .en  (neg_res_q),
        .din (acc_q),
        .dout(prod_fix)
    );

    // Shift-add: upper half accumulates, lower half holds the unconsumed multiplier bits.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: upper half is the partial remainder, lower half dividend/quotient.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign fits     = rem_sh >= {1'b0, opnd_q};
    assign div_next = {fits ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0],
                       acc_q[WIDTH-2:0], fits};

    // Next-state logic for the FSM and datapath.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d   = RUN;
                    count_d   = '0;
                    is_div_d  = op_is_div(op);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    b_zero_d  = (b == '0);
                    opnd_d    = op_is_div(op) ? b_abs : a_abs;
                    acc_d     = {{WIDTH{1'b0}}, op_is_div(op) ? a_abs : b_abs};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = is_div_q ? div_next : mul_next;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            opnd_q    <= '0;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = (state_q == RUN) | (state_q == FIX);
    assign done    = (state_q == DONE);
    assign hilo_we = done;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done, hilo_we;
    logic [31:0] hi, lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    mdu_iterative #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hilo_we(hilo_we),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Start cycle is the one ending at the posedge this task waits for.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the number of cycles after the start cycle at which done is seen (-1 on timeout).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if ({busy, done, hilo_we, hi, lo} !== 67'd0) $display("FAIL reset_outputs got %h want 0", {busy, done, hilo_we, hi, lo});
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_op(input string name, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        launch(o, x, y);
        wait_done(lat);
        total_cnt++;
        if (lat !== 34) $display("FAIL %s_latency got %0d want 34", name, lat);
        else pass_cnt++;
        total_cnt++;
        if ({hilo_we, hi, lo} !== {1'b1, exp_hi, exp_lo})
            $display("FAIL %s_result got we=%b hi=%h lo=%h want we=1 hi=%h lo=%h", name, hilo_we, hi, lo, exp_hi, exp_lo);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({done, hilo_we, busy} !== 3'b000) $display("FAIL %s_pulse got done/we/busy=%b want 000", name, {done, hilo_we, busy});
        else pass_cnt++;
        total_cnt++;
        if ({hi, lo} !== {exp_hi, exp_lo}) $display("FAIL %s_hold got %h want %h", name, {hi, lo}, {exp_hi, exp_lo});
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int lat;
        int extra = 0;
        launch(2'b11, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL start_busy_busy got %b want 1", busy);
        else pass_cnt++;
        wait_done(lat);
        total_cnt++;
        if (lat + 6 !== 34) $display("FAIL start_busy_latency got %0d want 34", lat + 6);
        else pass_cnt++;
        total_cnt++;
        if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL start_busy_result got %h want %h", {hi, lo}, {32'd2, 32'd14});
        else pass_cnt++;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL start_busy_queued got %0d extra dones want 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int seen = 0;
        launch(2'b00, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy);
        else pass_cnt++;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || hilo_we === 1'b1) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL flush_no_done got %0d dones want 0", seen);
        else pass_cnt++;
        total_cnt++;
        if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL flush_hilo got %h want %h", {hi, lo}, {32'd2, 32'd14});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done, hilo_we, hi, lo} !== 67'd0)
            $display("FAIL reset_mid_run got %h want 0", {busy, done, hilo_we, hi, lo});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL reset_mid_run_quiet got %0d active cycles want 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        total_cnt++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
            $display("FAIL b2b_first got %h want %h", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        else pass_cnt++;
        // Start asserted during the DONE cycle.
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        total_cnt++;
        if (lat !== 34) $display("FAIL b2b_latency got %0d want 34", lat);
        else pass_cnt++;
        total_cnt++;
        if ({hi, lo} !== {32'hFFFF_FFFE, 32'h0000_0001})
            $display("FAIL b2b_second got %h want %h", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_op("mult",     2'b00, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        test_op("multu",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        test_op("mult_pos", 2'b00, 32'd1000,     32'd3000,      32'h0000_0000, 32'd3000000);
        test_op("div",      2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_op("divu",     2'b11, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC);
        test_op("divu_zero", 2'b11, 32'd100,     32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
        test_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
        test_op("div_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        test_op("div_negb", 2'b10, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        test_start_ignored();
        test_flush();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
